// File: rtl/alu_pkg.sv
// Shared opcode map, handshake FSM encoding and flag bit positions for seq_alu.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_GT  = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam int FLAG_CMP   = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVER  = 2;
    localparam int FLAG_ZERO  = 3;
    localparam int NFLAGS     = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle for WIDTH cycles.
// done/prod are combinational so the caller can capture the product on the final iteration edge.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = (cnt_q != LAST);
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST);
    assign prod = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready in and out: single-cycle ops land in OUT after one edge,
// MUL iterates in alu_mul_seq and lands in OUT on its final iteration edge.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cmp,
    output logic             carry,
    output logic             over,
    output logic             zero
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [WIDTH-1:0]    result_hi_q, result_hi_d;
    logic [NFLAGS-1:0]   flags_q, flags_d;

    logic [WIDTH-1:0]    res_c;
    logic                cmp_c, carry_c, over_c;
    logic [SHW-1:0]      sh;
    logic [WIDTH:0]      sum_w, diff_w, shl_w, shr_w;
    logic signed [WIDTH:0] sra_w;

    logic                mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0]  mul_prod;

    assign sh     = b[SHW-1:0];
    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};
    // Extra bit beside the operand catches the last bit shifted out (0 when sh==0).
    assign shl_w  = {1'b0, a} << sh;
    assign shr_w  = {a, 1'b0} >> sh;
    assign sra_w  = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        res_c   = '0;
        cmp_c   = 1'b0;
        carry_c = 1'b0;
        over_c  = 1'b0;
        case (op)
            OP_ADD: begin
                {carry_c, res_c} = sum_w;
                over_c = (a[WIDTH-1] == b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {carry_c, res_c} = diff_w;
                over_c = (a[WIDTH-1] != b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: res_c = ~a;
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            OP_GT:  cmp_c = ($signed(a) > $signed(b));
            OP_EQ:  cmp_c = (a == b);
            OP_SHL: {carry_c, res_c} = shl_w;
            OP_SHR: {res_c, carry_c} = shr_w;
            OP_SRA: {res_c, carry_c} = sra_w;
            default: ;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        mul_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        result_d            = res_c;
                        result_hi_d         = '0;
                        flags_d[FLAG_CMP]   = cmp_c;
                        flags_d[FLAG_CARRY] = carry_c;
                        flags_d[FLAG_OVER]  = over_c;
                        flags_d[FLAG_ZERO]  = (res_c == '0);
                        state_d             = S_OUT;
                    end
                end
            end
            S_MUL: begin
                if (mul_busy && mul_done) begin
                    result_d            = mul_prod[WIDTH-1:0];
                    result_hi_d         = mul_prod[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_CMP]   = 1'b0;
                    flags_d[FLAG_CARRY] = 1'b0;
                    flags_d[FLAG_OVER]  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    flags_d[FLAG_ZERO]  = (mul_prod == '0);
                    state_d             = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cmp       = flags_q[FLAG_CMP];
    assign carry     = flags_q[FLAG_CARRY];
    assign over      = flags_q[FLAG_OVER];
    assign zero      = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8; outputs are sampled 1ns after the rising edge.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result, result_hi;
    logic       cmp, carry, over, zero;
    logic [19:0] obs;

    int checks = 0;
    int failures = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .cmp(cmp), .carry(carry),
        .over(over), .zero(zero)
    );

    always #5 clk = ~clk;

    // {result_hi, result, cmp, carry, over, zero}
    assign obs = {result_hi, result, cmp, carry, over, zero};

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (obs !== 20'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset: obs=%h rdy=%b vld=%b, need obs=00000 rdy=1 vld=0", obs, in_ready, out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue(4'd0, 8'h7F, 8'h01);
        checks++;
        if (out_valid !== 1'b1 || obs !== {8'h00, 8'h80, 4'b0010}) begin
            failures++;
            $display("FAIL add_ovf: vld=%b obs=%h, need vld=1 obs=%h", out_valid, obs, {8'h00, 8'h80, 4'b0010});
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_handshake: vld=%b rdy=%b, need 0/1", out_valid, in_ready);
        end
        issue(4'd0, 8'hFF, 8'h01);
        checks++;
        if (obs !== {8'h00, 8'h00, 4'b0101}) begin
            failures++;
            $display("FAIL add_carry: obs=%h, need %h", obs, {8'h00, 8'h00, 4'b0101});
        end
        consume();
    endtask

    task automatic test_sub();
        issue(4'd1, 8'h03, 8'h05);
        checks++;
        if (obs !== {8'h00, 8'hFE, 4'b0100}) begin
            failures++;
            $display("FAIL sub_borrow: obs=%h, need %h", obs, {8'h00, 8'hFE, 4'b0100});
        end
        consume();
        issue(4'd1, 8'h80, 8'h01);
        checks++;
        if (obs !== {8'h00, 8'h7F, 4'b0010}) begin
            failures++;
            $display("FAIL sub_ovf: obs=%h, need %h", obs, {8'h00, 8'h7F, 4'b0010});
        end
        consume();
    endtask

    task automatic test_compare();
        issue(4'd6, 8'hFE, 8'h01);
        checks++;
        if (obs !== {8'h00, 8'h00, 4'b0001}) begin
            failures++;
            $display("FAIL gt_neg: obs=%h, need %h", obs, {8'h00, 8'h00, 4'b0001});
        end
        consume();
        issue(4'd6, 8'h01, 8'hFE);
        checks++;
        if (obs !== {8'h00, 8'h00, 4'b1001}) begin
            failures++;
            $display("FAIL gt_pos: obs=%h, need %h", obs, {8'h00, 8'h00, 4'b1001});
        end
        consume();
        issue(4'd7, 8'h5A, 8'h5A);
        checks++;
        if (obs !== {8'h00, 8'h00, 4'b1001}) begin
            failures++;
            $display("FAIL eq: obs=%h, need %h", obs, {8'h00, 8'h00, 4'b1001});
        end
        consume();
    endtask

    task automatic test_mul();
        int early_bad;
        early_bad = 0;
        issue(4'd8, 8'hFF, 8'hFF);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k < 8 && (out_valid !== 1'b0 || in_ready !== 1'b0)) early_bad++;
            if (k == 1 && in_ready !== 1'b0) early_bad++;
        end
        checks++;
        if (early_bad != 0) begin
            failures++;
            $display("FAIL mul_busy: early_bad=%0d, need 0", early_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== {8'hFE, 8'h01, 4'b0010}) begin
            failures++;
            $display("FAIL mul_result: vld=%b rdy=%b obs=%h, need 1/0 %h", out_valid, in_ready, obs, {8'hFE, 8'h01, 4'b0010});
        end
        consume();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        issue(4'd11, 8'h90, 8'h03);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k == 1 || k == 2);
            op = 4'd0; a = 8'h01; b = 8'h01;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== {8'h00, 8'hF2, 4'b0000}) bad++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0 || obs !== {8'h00, 8'hF2, 4'b0000}) begin
            failures++;
            $display("FAIL sra_hold: bad=%0d obs=%h, need 0 %h", bad, obs, {8'h00, 8'hF2, 4'b0000});
        end
        consume();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'hF2) begin
            failures++;
            $display("FAIL ignored_pulse: vld=%b rdy=%b res=%h, need 0 1 f2", out_valid, in_ready, result);
        end
    endtask

    task automatic test_reserved();
        issue(4'd13, 8'hA5, 8'h3C);
        checks++;
        if (out_valid !== 1'b1 || obs !== {8'h00, 8'h00, 4'b0001}) begin
            failures++;
            $display("FAIL reserved: vld=%b obs=%h, need 1 %h", out_valid, obs, {8'h00, 8'h00, 4'b0001});
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [5] = '{4'd2, 4'd5, 4'd9, 4'd10, 4'd4};
        logic [7:0]  av  [5] = '{8'h0F, 8'hF0, 8'h81, 8'h03, 8'h00};
        logic [7:0]  bv  [5] = '{8'h00, 8'h3C, 8'h01, 8'h01, 8'h00};
        logic [19:0] ev  [5] = '{{8'h00, 8'hF0, 4'b0000}, {8'h00, 8'hCC, 4'b0000},
                                 {8'h00, 8'h02, 4'b0100}, {8'h00, 8'h01, 4'b0100},
                                 {8'h00, 8'h00, 4'b0001}};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], av[i], bv[i]);
            checks++;
            if (out_valid !== 1'b1 || obs !== ev[i]) begin
                failures++;
                $display("FAIL b2b_%0d: vld=%b obs=%h, need 1 %h", i, out_valid, obs, ev[i]);
            end
            consume();
        end
    endtask

    task automatic test_reset_mid_mul();
        int stale;
        stale = 0;
        issue(4'd8, 8'h0F, 8'h0F);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: obs=%h vld=%b rdy=%b, need 00000 0 1", obs, out_valid, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL reset_stale: stale=%0d, need 0", stale);
        end
        issue(4'd0, 8'h02, 8'h03);
        checks++;
        if (out_valid !== 1'b1 || obs !== {8'h00, 8'h05, 4'b0000}) begin
            failures++;
            $display("FAIL post_reset_add: vld=%b obs=%h, need 1 %h", out_valid, obs, {8'h00, 8'h05, 4'b0000});
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_mul();
        test_backpressure();
        test_reserved();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
